// File: rtl/data_bus_responder.sv
// data_bus_responder: fixed-latency load/store responder over a word RAM, an LED register and a cycle counter.
// Define DBR_CYCLE_COUNTER_EN to build the cycle counter; without it, reads of 0xFFFC return 0.
module data_bus_responder #(
  parameter int DEPTH   = 64,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        ready,
  output logic        ack,
  output logic [31:0] rdata,
  output logic        err,
  output logic [15:0] led
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = LATENCY > 2 ? $clog2(LATENCY) : 1;
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
  state_t        state_q, state_d;
  logic [CW-1:0] wait_q, wait_d;
  logic          we_q, we_d, err_q, err_d;
  logic [31:0]   addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
  logic [15:0]   led_q, led_d;
  logic [31:0]   mem [DEPTH];
  logic [31:0]   a, rd_val, cycles;
  logic          w, accept, enter_resp, commit, hit_ram, hit_led, hit_cnt, fault;
`ifdef DBR_CYCLE_COUNTER_EN
  logic [31:0] cycles_q, cycles_d;
  always_comb cycles_d = cycles_q + 32'd1;
  always_ff @(posedge clk)
    cycles_q <= !reset ? '0 : cycles_d;
  assign cycles = cycles_q;
`else
  assign cycles = '0;
`endif
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      wait_q  <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      led_q   <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      led_q   <= led_d;
    end
  end
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    case (state_q)
      IDLE: if (req) begin
        state_d = LATENCY == 1 ? RESP : BUSY;
        wait_d  = CW'(LATENCY - 2);
      end
      BUSY: begin
        state_d = wait_q == '0 ? RESP : BUSY;
        wait_d  = wait_q - CW'(1);
      end
      default: state_d = IDLE;
    endcase
  end
  // In IDLE the access being decoded is the one on the inputs (LATENCY=1 enters RESP at acceptance).
  always_comb begin
    accept     = state_q == IDLE && req;
    a          = state_q == IDLE ? addr : addr_q;
    w          = state_q == IDLE ? we : we_q;
    hit_ram    = a[31:AW+2] == '0;
    hit_led    = a == 32'h0000_FFF0;
    hit_cnt    = a == 32'h0000_FFFC;
    fault      = a[1:0] != 2'b00 || !(hit_ram || hit_led || hit_cnt);
    rd_val     = hit_ram ? mem[a[AW+1:2]] : hit_led ? {16'h0, led_q} : hit_cnt ? cycles : '0;
    enter_resp = state_d == RESP && state_q != RESP;
    commit     = state_q == RESP && we_q && !fault && reset;
    we_d       = accept ? we : we_q;
    addr_d     = accept ? addr : addr_q;
    wdata_d    = accept ? wdata : wdata_q;
    rdata_d    = !enter_resp ? rdata_q : fault ? '0 : w ? rdata_q : rd_val;
    err_d      = enter_resp && fault;
    led_d      = commit && hit_led ? wdata_q[15:0] : led_q;
  end
  always_ff @(posedge clk)
    if (commit && hit_ram) mem[a[AW+1:2]] <= wdata_q;
  always_comb begin
    ready = state_q == IDLE;
    ack   = state_q == RESP;
    err   = ack && err_q;
    rdata = rdata_q;
    led   = led_q;
  end
endmodule

// File: tb/tb_data_bus_responder.sv
// tb_data_bus_responder: directed load/store scenarios against hand-computed results.
module tb_data_bus_responder;
  logic        clk = 1'b0, reset = 1'b0, req = 1'b0, we = 1'b0;
  logic [31:0] addr = '0, wdata = '0;
  logic        ready, ack, err;
  logic [31:0] rdata;
  logic [15:0] led;
  int total = 0, passed = 0, tb_cyc = 0, acc_cyc = 0;
  data_bus_responder #(.DEPTH(64), .LATENCY(2)) dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .ready(ready), .ack(ack), .rdata(rdata), .err(err), .led(led)
  );
  always #5 clk = ~clk;
  always @(posedge clk) tb_cyc <= tb_cyc + 1;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h, expected %h", tag, got, exp);
  endtask
  task automatic access(input string tag, input logic w, input logic [31:0] a, input logic [31:0] d,
                        output logic [31:0] rd, output logic e);
    int n, lat;
    n = 0;
    while (!ready && n < 20) begin @(posedge clk); #1; n++; end
    req = 1'b1; we = w; addr = a; wdata = d;
    @(posedge clk); #1;
    acc_cyc = tb_cyc;
    req = 1'b0;
    chk({tag, "_busy_ready"}, {31'b0, ready}, 32'd0);
    lat = 1;
    while (!ack && lat < 20) begin @(posedge clk); #1; lat++; end
    chk({tag, "_latency"}, lat, 32'd2);
    rd = rdata; e = err;
    @(posedge clk); #1;
    chk({tag, "_ready_back"}, {31'b0, ready}, 32'd1);
    chk({tag, "_err_idle"}, {31'b0, err}, 32'd0);
    chk({tag, "_rdata_hold"}, rdata, rd);
  endtask
  logic [31:0] r, r1;
  logic        e;
  int          n, c1;
  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", {31'b0, ready}, 32'd1);
    chk("rst_ack", {31'b0, ack}, 32'd0);
    chk("rst_err", {31'b0, err}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_led", {16'b0, led}, 32'd0);
    reset = 1'b1;
    access("st8", 1'b1, 32'h8, 32'h12345678, r, e);
    chk("st8_err", {31'b0, e}, 32'd0);
    access("ld8", 1'b0, 32'h8, 32'h0, r, e);
    chk("ld8_rdata", r, 32'h12345678);
    chk("ld8_err", {31'b0, e}, 32'd0);
    access("st_led", 1'b1, 32'hFFF0, 32'hABCD5A5A, r, e);
    chk("led_value", {16'b0, led}, 32'h5A5A);
    access("ld_led", 1'b0, 32'hFFF0, 32'h0, r, e);
    chk("ld_led_rdata", r, 32'h00005A5A);
    chk("ld_led_err", {31'b0, e}, 32'd0);
    access("ld_mis", 1'b0, 32'h6, 32'h0, r, e);
    chk("ld_mis_err", {31'b0, e}, 32'd1);
    chk("ld_mis_rdata", r, 32'd0);
    access("ld_unmap", 1'b0, 32'h100, 32'h0, r, e);
    chk("ld_unmap_err", {31'b0, e}, 32'd1);
    chk("ld_unmap_rdata", r, 32'd0);
    access("st_mis", 1'b1, 32'h9, 32'hDEADBEEF, r, e);
    chk("st_mis_err", {31'b0, e}, 32'd1);
    access("st_cnt", 1'b1, 32'hFFFC, 32'h55555555, r, e);
    chk("st_cnt_err", {31'b0, e}, 32'd0);
    access("ld8_again", 1'b0, 32'h8, 32'h0, r, e);
    chk("ld8_again_rdata", r, 32'h12345678);
    chk("led_unchanged", {16'b0, led}, 32'h5A5A);
    for (int i = 0; i < 9; i++) access("preload", 1'b1, 32'h10 + 32'(4 * i), 32'hC0DE0000 + 32'(i), r, e);
    req = 1'b1; we = 1'b0; n = 0;
    for (int i = 0; i < 9; i++) begin
      addr = 32'h10 + 32'(4 * i);
      @(posedge clk); #1;
      if (ack) begin
        chk("burst_rdata", rdata, 32'hC0DE0000 + 32'(3 * n));
        n++;
      end
    end
    req = 1'b0;
    chk("burst_acks", n, 32'd3);
    access("st4", 1'b1, 32'h4, 32'h0BADF00D, r, e);
    req = 1'b1; we = 1'b1; addr = 32'h4; wdata = 32'hFFFFFFFF;
    @(posedge clk); #1;
    req = 1'b0;
    chk("abort_busy", {31'b0, ready}, 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    chk("abort_ready", {31'b0, ready}, 32'd1);
    chk("abort_rdata", rdata, 32'd0);
    chk("abort_led", {16'b0, led}, 32'd0);
    n = 0;
    repeat (4) begin @(posedge clk); #1; n += int'(ack); end
    chk("abort_noack", n, 32'd0);
    access("ld4", 1'b0, 32'h4, 32'h0, r, e);
    chk("ld4_rdata", r, 32'h0BADF00D);
    access("cnt1", 1'b0, 32'hFFFC, 32'h0, r1, e);
    chk("cnt1_err", {31'b0, e}, 32'd0);
    c1 = acc_cyc;
    repeat (5) @(posedge clk);
    #1;
    access("cnt2", 1'b0, 32'hFFFC, 32'h0, r, e);
    chk("cnt2_err", {31'b0, e}, 32'd0);
`ifdef DBR_CYCLE_COUNTER_EN
    chk("cnt_diff", r - r1, 32'(acc_cyc - c1));
`else
    chk("cnt1_zero", r1, 32'd0);
    chk("cnt2_zero", r, 32'd0);
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end
endmodule
